// File: rtl/axis_mvm_tile_if.sv
// AXI-stream channel bundle used on both sides of the MVM tile.
// Master drives payload and valid; slave drives ready.
interface axis_mvm_tile_if #(
    parameter int DATAW = 32,
    parameter int USERW = 32,
    parameter int DESTW = 6
);
    logic             tvalid;
    logic             tready;
    logic             tlast;
    logic [DATAW-1:0] tdata;
    logic [USERW-1:0] tuser;
    logic [DESTW-1:0] tdest;

    modport master (output tvalid, tdata, tuser, tdest, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tdest, tlast, output tready);
endinterface

// File: rtl/axis_mvm_tile.sv
// Weight-stationary matrix-vector tile: NROWS signed dot products per input vector,
// requantised and packed OLANES per output word; also a lane-wise legacy multiply.
module axis_mvm_tile #(
    parameter int DATAW      = 32,
    parameter int IPRECISION = 8,
    parameter int OPRECISION = 8,
    parameter int NROWS      = 8,
    parameter int USERW      = 32,
    parameter int DESTW      = 6
) (
    input  logic            clk,
    input  logic            rst,
    axis_mvm_tile_if.slave  axis_rx,
    axis_mvm_tile_if.master axis_tx
);
    localparam int LANES  = DATAW / IPRECISION;
    localparam int OLANES = DATAW / OPRECISION;
    localparam int RW     = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int PW     = 2 * IPRECISION;
    localparam int DOTW   = PW + $clog2(LANES);
    localparam logic signed [DOTW-1:0] QMAX = DOTW'((1 << (OPRECISION - 1)) - 1);
    localparam logic signed [DOTW-1:0] QMIN = ~QMAX;

    typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, OUTPUT = 2'd2} state_t;

    state_t state, state_nxt;

    logic [DATAW-1:0] weights [NROWS];
    logic [DATAW-1:0] x_reg, pack_reg, pack_nxt, legacy_dat, tx_dat;
    logic [DATAW-1:0] w_sel, w_row;
    logic             sat_reg, tx_vld, tx_last, rx_ready, rx_acc;
    logic [4:0]       shift_reg;
    logic [RW-1:0]    row_cnt, row_raw, row_sel;
    logic [1:0]       rx_op;
    int               lane;
    logic             lane_last, row_last;

    logic signed [IPRECISION-1:0] xa, wa, xd, wd;
    logic signed [PW-1:0]         pa, pd;
    logic signed [DOTW-1:0]       dot, shifted;
    logic [OPRECISION-1:0]        q;

    assign rx_op     = axis_rx.tuser[USERW-1 -: 2];
    assign row_raw   = axis_rx.tuser[RW-1:0];
    assign row_sel   = (int'(row_raw) >= NROWS) ? RW'(int'(row_raw) - NROWS) : row_raw;
    assign rx_acc    = axis_rx.tvalid && rx_ready;
    assign w_sel     = weights[row_sel];
    assign w_row     = weights[row_cnt];
    assign lane      = int'(row_cnt) % OLANES;
    assign lane_last = (lane == OLANES - 1);
    assign row_last  = (int'(row_cnt) == NROWS - 1);

    assign axis_rx.tready = rx_ready;
    assign axis_tx.tvalid = tx_vld;
    assign axis_tx.tdata  = tx_dat;
    assign axis_tx.tlast  = tx_last;
    assign axis_tx.tuser  = '0;
    assign axis_tx.tdest  = {DESTW{1'b0}};

    logic unused_rx;
    assign unused_rx = ^{axis_rx.tdest, axis_rx.tlast, axis_rx.tuser};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rx_acc) begin
                    if (rx_op == 2'd1)      state_nxt = OUTPUT;
                    else if (rx_op == 2'd2) state_nxt = COMPUTE;
                end
            end
            COMPUTE: if (lane_last) state_nxt = OUTPUT;
            OUTPUT:  if (tx_vld && axis_tx.tready) state_nxt = tx_last ? IDLE : COMPUTE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = (state == IDLE);
    end

    always_comb begin
        legacy_dat = '0;
        xa = '0;
        wa = '0;
        pa = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < OLANES) begin
                xa = axis_rx.tdata[i*IPRECISION +: IPRECISION];
                wa = w_sel[i*IPRECISION +: IPRECISION];
                pa = PW'(xa) * PW'(wa);
                legacy_dat[i*OPRECISION +: OPRECISION] = pa[OPRECISION-1:0];
            end
        end
    end

    // Full-precision accumulate: DOTW leaves headroom for every lane at the extreme product.
    always_comb begin
        dot = '0;
        xd  = '0;
        wd  = '0;
        pd  = '0;
        for (int i = 0; i < LANES; i++) begin
            xd  = x_reg[i*IPRECISION +: IPRECISION];
            wd  = w_row[i*IPRECISION +: IPRECISION];
            pd  = PW'(xd) * PW'(wd);
            dot = dot + DOTW'(pd);
        end
    end

    always_comb begin
        shifted = dot >>> shift_reg;
        q       = shifted[OPRECISION-1:0];
        if (sat_reg) begin
            if (shifted > QMAX)      q = QMAX[OPRECISION-1:0];
            else if (shifted < QMIN) q = QMIN[OPRECISION-1:0];
        end
        pack_nxt = pack_reg;
        pack_nxt[lane*OPRECISION +: OPRECISION] = q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NROWS; i++) weights[i] <= '0;
            x_reg     <= '0;
            sat_reg   <= 1'b0;
            shift_reg <= '0;
            row_cnt   <= '0;
            pack_reg  <= '0;
            tx_vld    <= 1'b0;
            tx_dat    <= '0;
            tx_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_acc) begin
                        case (rx_op)
                            2'd3: weights[row_sel] <= axis_rx.tdata;
                            2'd1: begin
                                tx_dat  <= legacy_dat;
                                tx_last <= 1'b1;
                                tx_vld  <= 1'b1;
                            end
                            2'd2: begin
                                x_reg     <= axis_rx.tdata;
                                sat_reg   <= axis_rx.tuser[USERW-3];
                                shift_reg <= axis_rx.tuser[USERW-4 -: 5];
                                row_cnt   <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                COMPUTE: begin
                    pack_reg <= pack_nxt;
                    if (lane_last) begin
                        tx_dat  <= pack_nxt;
                        tx_vld  <= 1'b1;
                        tx_last <= row_last;
                    end else begin
                        row_cnt <= row_cnt + RW'(1);
                    end
                end
                OUTPUT: begin
                    // Word is held until taken; the row counter only advances on the handshake.
                    if (tx_vld && axis_tx.tready) begin
                        tx_vld <= 1'b0;
                        if (!tx_last) row_cnt <= row_cnt + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_mvm_tile.sv
// Randomised bench for axis_mvm_tile with an arithmetic reference model.
module tb_axis_mvm_tile;
    localparam int DATAW = 32, IPRECISION = 8, OPRECISION = 8, NROWS = 8;
    localparam int USERW = 32, DESTW = 6, LANES = 4, OLANES = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axis_mvm_tile_if #(.DATAW(DATAW), .USERW(USERW), .DESTW(DESTW)) rx_if ();
    axis_mvm_tile_if #(.DATAW(DATAW), .USERW(USERW), .DESTW(DESTW)) tx_if ();

    axis_mvm_tile #(
        .DATAW(DATAW), .IPRECISION(IPRECISION), .OPRECISION(OPRECISION),
        .NROWS(NROWS), .USERW(USERW), .DESTW(DESTW)
    ) dut (
        .clk(clk), .rst(rst), .axis_rx(rx_if), .axis_tx(tx_if)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] ref_w [NROWS];
    logic [31:0] exp_dat [$];
    logic        exp_last [$];
    logic [31:0] obs_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_row(input logic [31:0] x, input int r, input logic sat, input int shift);
        int  dot, qv;
        byte a, b;
        dot = 0;
        for (int i = 0; i < LANES; i++) begin
            a = x[i*8 +: 8];
            b = ref_w[r][i*8 +: 8];
            dot += int'(a) * int'(b);
        end
        qv = dot >>> shift;
        if (sat) begin
            if (qv > 127) qv = 127;
            else if (qv < -128) qv = -128;
        end
        return qv[7:0];
    endfunction

    task automatic expect_mvm(input logic [31:0] x, input logic sat, input int shift);
        logic [31:0] word;
        for (int w = 0; w < NROWS / OLANES; w++) begin
            word = '0;
            for (int l = 0; l < OLANES; l++) word[l*8 +: 8] = ref_row(x, w * OLANES + l, sat, shift);
            exp_dat.push_back(word);
            exp_last.push_back(w == NROWS / OLANES - 1);
        end
    endtask

    task automatic expect_legacy(input logic [31:0] x, input int row);
        logic [31:0] word;
        byte         a, b;
        int          p;
        word = '0;
        for (int i = 0; i < LANES; i++) begin
            a = x[i*8 +: 8];
            b = ref_w[row][i*8 +: 8];
            p = int'(a) * int'(b);
            word[i*8 +: 8] = p[7:0];
        end
        exp_dat.push_back(word);
        exp_last.push_back(1'b1);
    endtask

    task automatic send(input logic [1:0] op, input logic sat, input logic [4:0] shift,
                        input logic [2:0] row, input logic [31:0] data);
        logic [31:0] u;
        int          n;
        u = '0;
        u[31:30] = op;
        u[29]    = sat;
        u[28:24] = shift;
        u[23:3]  = 21'($urandom);
        u[2:0]   = row;
        @(negedge clk);
        rx_if.tvalid = 1'b1;
        rx_if.tdata  = data;
        rx_if.tuser  = u;
        rx_if.tdest  = 6'($urandom);
        n = 0;
        while (!rx_if.tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rx_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        rx_if.tvalid = 1'b0;
        if (op == 2'd3) ref_w[row] = data;
    endtask

    task automatic count_to_valid(output int cnt);
        cnt = 0;
        while (!tx_if.tvalid && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic collect(input int max_stall);
        logic [31:0] d;
        logic        l;
        int          n, stall;
        obs_q.delete();
        while (exp_dat.size() > 0) begin
            n = 0;
            while (!tx_if.tvalid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                chk("tx_timeout", 0, 1);
                exp_dat.delete();
                exp_last.delete();
                return;
            end
            d = exp_dat.pop_front();
            l = exp_last.pop_front();
            obs_q.push_back(tx_if.tdata);
            chk("tx_tdata", tx_if.tdata, d);
            chk("tx_tlast", tx_if.tlast, l);
            chk("rx_tready_busy", rx_if.tready, 0);
            stall = $urandom_range(max_stall, 0);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("tx_hold", {tx_if.tvalid, tx_if.tdata}, {1'b1, d});
            end
            tx_if.tready = 1'b1;
            @(posedge clk);
            #1;
            tx_if.tready = 1'b0;
        end
        chk("rx_tready_idle", rx_if.tready, 1);
    endtask

    initial begin
        int          cnt;
        logic [31:0] x;
        logic        sat;
        logic [4:0]  sh;
        logic [2:0]  row;

        rx_if.tvalid = 1'b0;
        rx_if.tdata  = '0;
        rx_if.tuser  = '0;
        rx_if.tdest  = '0;
        rx_if.tlast  = 1'b0;
        tx_if.tready = 1'b0;
        for (int i = 0; i < NROWS; i++) ref_w[i] = '0;

        #1 rst = 1'b1;
        #2;
        chk("rst_tvalid", tx_if.tvalid, 0);
        chk("rst_tdata", tx_if.tdata, 0);
        chk("rst_tlast", tx_if.tlast, 0);
        chk("rst_rx_tready", rx_if.tready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Legacy lane-wise multiply
        send(2'd3, 0, 0, 0, 32'h03030303);
        send(2'd1, 0, 0, 0, 32'h05050505);
        chk("leg_valid_after_accept", tx_if.tvalid, 1);
        expect_legacy(32'h05050505, 0);
        collect(0);
        chk("leg_a_const", obs_q[0], 32'h0F0F0F0F);
        send(2'd3, 0, 0, 0, 32'hFD000000);
        send(2'd1, 0, 0, 0, 32'h05000000);
        expect_legacy(32'h05000000, 0);
        collect(1);
        chk("leg_b_const", obs_q[0], 32'hF1000000);

        // MVM, wrap, shift 0, with backpressure on word0
        send(2'd3, 0, 0, 0, 32'h01010101);
        send(2'd3, 0, 0, 1, 32'h02020202);
        send(2'd3, 0, 0, 2, 32'hFFFFFFFF);
        send(2'd3, 0, 0, 3, 32'h00000000);
        for (int r = 4; r < 8; r++) send(2'd3, 0, 0, 3'(r), 32'h7F7F7F7F);
        expect_mvm(32'h01020304, 0, 0);
        send(2'd2, 0, 0, 0, 32'h01020304);
        count_to_valid(cnt);
        chk("mvm_first_latency", cnt, OLANES);
        chk("mvm_w0_const", tx_if.tdata, 32'h00F6140A);
        chk("mvm_w0_model", tx_if.tdata, exp_dat[0]);
        chk("mvm_w0_tlast", tx_if.tlast, 0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("bp_hold", {tx_if.tvalid, tx_if.tdata}, {1'b1, 32'h00F6140A});
            chk("bp_rx_tready", rx_if.tready, 0);
        end
        @(negedge clk);
        tx_if.tready = 1'b1;
        @(posedge clk);
        #1;
        tx_if.tready = 1'b0;
        void'(exp_dat.pop_front());
        void'(exp_last.pop_front());
        chk("bp_w0_drop", tx_if.tvalid, 0);
        count_to_valid(cnt);
        chk("mvm_word_gap", cnt, OLANES);
        collect(0);
        chk("mvm_w1_const", obs_q[0], 32'hF6F6F6F6);

        // Saturating requantisation
        expect_mvm(32'h01020304, 1, 0);
        send(2'd2, 1, 0, 0, 32'h01020304);
        collect(2);
        chk("sat0_w0", obs_q[0], 32'h00F6140A);
        chk("sat0_w1", obs_q[1], 32'h7F7F7F7F);
        expect_mvm(32'h01020304, 1, 4);
        send(2'd2, 1, 5'd4, 0, 32'h01020304);
        collect(2);
        chk("sat4_w0", obs_q[0], 32'h00FF0100);
        chk("sat4_w1", obs_q[1], 32'h4F4F4F4F);

        // Random weights and operations
        for (int r = 0; r < NROWS; r++) send(2'd3, 0, 0, 3'(r), $urandom);
        for (int it = 0; it < 24; it++) begin
            x   = $urandom;
            sat = 1'($urandom);
            sh  = 5'($urandom_range(31, 0));
            row = 3'($urandom);
            case ($urandom_range(3, 0))
                0: send(2'd3, 0, 0, row, $urandom);
                1: begin
                    expect_legacy(x, int'(row));
                    send(2'd1, sat, sh, row, x);
                    collect(2);
                end
                default: begin
                    expect_mvm(x, sat, int'(sh));
                    send(2'd2, sat, sh, row, x);
                    collect(2);
                end
            endcase
        end

        // op 0 is swallowed without output or weight change
        send(2'd0, 1, 5'd3, 3'd5, $urandom);
        chk("op0_rx_tready", rx_if.tready, 1);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_if.tvalid) cnt++;
        end
        chk("op0_no_output", cnt, 0);
        expect_legacy(32'h05050505, 5);
        send(2'd1, 0, 0, 3'd5, 32'h05050505);
        collect(0);

        // Reset in the middle of COMPUTE
        send(2'd2, 0, 0, 0, 32'h01020304);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", tx_if.tvalid, 0);
        chk("midrst_rx_tready", rx_if.tready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NROWS; i++) ref_w[i] = '0;
        @(negedge clk);
        chk("postrst_rx_tready", rx_if.tready, 1);
        chk("postrst_tvalid", tx_if.tvalid, 0);
        expect_legacy(32'h05050505, 0);
        send(2'd1, 0, 0, 0, 32'h05050505);
        collect(0);
        chk("postrst_leg_const", obs_q[0], 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
